ddr_axi_rd: RTL and testbench

DDR_AXI_RD -- requirements
Module: ddr_axi_rd

---
 rtl/ddr_axi_rd.sv | 169 ++++++++++++++++
 tb/tb_ddr_axi_rd.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_axi_rd.sv
// AXI4 read master: turns a (start address, beats per burst, burst count) command
// into back-to-back INCR bursts with one outstanding, streaming read data into a FIFO.
module ddr_axi_rd #(
  parameter int DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH      = 29,
  parameter int BURST_LEN_WIDTH = 8,
  parameter int NUM_BURST_WIDTH = 8,
  parameter int ID_WIDTH        = 4
) (
  input  logic                       clk,
  input  logic                       rstn,

  input  logic                       rd_start,
  input  logic [BURST_LEN_WIDTH-1:0] rd_burst_len,
  input  logic [NUM_BURST_WIDTH-1:0] rd_num_burst,
  input  logic [ADDR_WIDTH-1:0]      rd_start_addr,
  output logic                       rd_ready,
  output logic                       rd_done,
  output logic                       rd_err,

  output logic                       rd_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]      rd_fifo_wr_data,
  input  logic                       rd_fifo_full,

  output logic [ID_WIDTH-1:0]        m_axi_arid,
  output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [7:0]                 m_axi_arlen,
  output logic [2:0]                 m_axi_arsize,
  output logic [1:0]                 m_axi_arburst,
  output logic                       m_axi_arvalid,
  input  logic                       m_axi_arready,

  input  logic [ID_WIDTH-1:0]        m_axi_rid,
  input  logic [DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [1:0]                 m_axi_rresp,
  input  logic                       m_axi_rlast,
  input  logic                       m_axi_rvalid,
  output logic                       m_axi_rready
);

  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int SIZE_LOG2 = $clog2(BYTES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  state_t                     state_q, state_d;
  logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
  logic [BURST_LEN_WIDTH-1:0] beat_q, beat_d;
  logic [NUM_BURST_WIDTH-1:0] left_q, left_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic                       err_q, err_d;

  logic [BURST_LEN_WIDTH-1:0] beat_next;
  logic [ADDR_WIDTH-1:0]      step;
  logic                       beat_acc;

  // Single outstanding burst, so the returned ID carries no information.
  logic unused_ok;
  assign unused_ok = ^{m_axi_rid, m_axi_rresp[0]};

  assign beat_next = beat_q + 1'b1;
  assign step      = ADDR_WIDTH'(len_q) << SIZE_LOG2;
  assign beat_acc  = (state_q == S_DATA) && m_axi_rvalid && !rd_fifo_full;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      left_q  <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      left_q  <= left_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    beat_d        = beat_q;
    left_d        = left_q;
    addr_d        = addr_q;
    err_d         = err_q;
    rd_ready      = 1'b0;
    rd_done       = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        rd_ready = 1'b1;
        if (rd_start) begin
          len_d  = rd_burst_len;
          left_d = rd_num_burst;
          addr_d = rd_start_addr;
          beat_d = '0;
          err_d  = 1'b0;
          if ((rd_burst_len == '0) || (rd_num_burst == '0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        m_axi_rready = !rd_fifo_full;
        if (beat_acc) begin
          beat_d = beat_next;
          if (m_axi_rresp[1]) begin
            err_d = 1'b1;
          end
          // The slave's rlast ends the burst even when it disagrees with our count.
          if (m_axi_rlast) begin
            if (beat_next != len_q) begin
              err_d = 1'b1;
            end
            beat_d = '0;
            addr_d = addr_q + step;
            left_d = left_q - 1'b1;
            if (left_q != NUM_BURST_WIDTH'(1)) begin
              state_d = S_ADDR;
            end else begin
              state_d = S_DONE;
            end
          end else if (beat_next == len_q) begin
            err_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        rd_done = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign rd_err          = err_q;
  assign rd_fifo_wr_en   = beat_acc;
  assign rd_fifo_wr_data = m_axi_rdata;

  assign m_axi_arid    = '0;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = (state_q == S_ADDR) ? 8'(len_q - 1'b1) : '0;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;

endmodule

// File: tb/tb_ddr_axi_rd.sv
// Self-checking bench for ddr_axi_rd: AXI slave model with a data scoreboard,
// AR stalls, FIFO back-pressure, error injection and mid-transfer reset.
module tb_ddr_axi_rd;

  localparam int DW  = 64;
  localparam int AW  = 29;
  localparam int BLW = 8;
  localparam int NBW = 8;
  localparam int IDW = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           rd_start;
  logic [BLW-1:0] rd_burst_len;
  logic [NBW-1:0] rd_num_burst;
  logic [AW-1:0]  rd_start_addr;
  logic           rd_ready, rd_done, rd_err;
  logic           rd_fifo_wr_en;
  logic [DW-1:0]  rd_fifo_wr_data;
  logic           rd_fifo_full;
  logic [IDW-1:0] m_axi_arid;
  logic [AW-1:0]  m_axi_araddr;
  logic [7:0]     m_axi_arlen;
  logic [2:0]     m_axi_arsize;
  logic [1:0]     m_axi_arburst;
  logic           m_axi_arvalid, m_axi_arready;
  logic [IDW-1:0] m_axi_rid;
  logic [DW-1:0]  m_axi_rdata;
  logic [1:0]     m_axi_rresp;
  logic           m_axi_rlast, m_axi_rvalid, m_axi_rready;

  always #5 clk = ~clk;

  ddr_axi_rd #(
    .DATA_WIDTH      (DW),
    .ADDR_WIDTH      (AW),
    .BURST_LEN_WIDTH (BLW),
    .NUM_BURST_WIDTH (NBW),
    .ID_WIDTH        (IDW)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .rd_start        (rd_start),
    .rd_burst_len    (rd_burst_len),
    .rd_num_burst    (rd_num_burst),
    .rd_start_addr   (rd_start_addr),
    .rd_ready        (rd_ready),
    .rd_done         (rd_done),
    .rd_err          (rd_err),
    .rd_fifo_wr_en   (rd_fifo_wr_en),
    .rd_fifo_wr_data (rd_fifo_wr_data),
    .rd_fifo_full    (rd_fifo_full),
    .m_axi_arid      (m_axi_arid),
    .m_axi_araddr    (m_axi_araddr),
    .m_axi_arlen     (m_axi_arlen),
    .m_axi_arsize    (m_axi_arsize),
    .m_axi_arburst   (m_axi_arburst),
    .m_axi_arvalid   (m_axi_arvalid),
    .m_axi_arready   (m_axi_arready),
    .m_axi_rid       (m_axi_rid),
    .m_axi_rdata     (m_axi_rdata),
    .m_axi_rresp     (m_axi_rresp),
    .m_axi_rlast     (m_axi_rlast),
    .m_axi_rvalid    (m_axi_rvalid),
    .m_axi_rready    (m_axi_rready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int n);
    return {32'hD0A7_0000 + 32'(n), ~32'(n)};
  endfunction

  logic [63:0]   exp_q[$];
  logic [AW-1:0] ar_exp_q[$];
  int            burst_q[$];

  int cur_len = 1, ar_delay = 0, ar_hold = 0;
  int early_last = -1, resp_err_beat = -1, stall_at = -1, stall_left = 0;
  int gbeat = 0, b_len = 0, b_idx = 0;
  int pushes = 0, done_cnt = 0, cyc = 0, last_cyc = 0, ar_seen = 0, stall_seen = 0;
  bit active = 1'b0, presented = 1'b0, data_cmd = 1'b0, acc_ar;

  // AXI slave + FIFO model: inputs set at the falling edge, outputs sampled 1 later.
  initial begin
    m_axi_arready = 1'b0;
    m_axi_rvalid  = 1'b0;
    m_axi_rdata   = '0;
    m_axi_rresp   = 2'b00;
    m_axi_rlast   = 1'b0;
    m_axi_rid     = '0;
    rd_fifo_full  = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rstn) begin
        burst_q.delete();
        active = 1'b0; presented = 1'b0; ar_hold = 0; stall_left = 0;
        m_axi_rvalid = 1'b1; m_axi_rlast = 1'b1; m_axi_arready = 1'b1; rd_fifo_full = 1'b0;
        #1;
        chk("rst_rready", m_axi_rready, 1'b0);
        chk("rst_wr_en", rd_fifo_wr_en, 1'b0);
        chk("rst_arvalid", m_axi_arvalid, 1'b0);
      end else begin
        rd_fifo_full = (stall_left > 0);
        if (!active && burst_q.size() > 0) begin
          b_len = burst_q.pop_front(); b_idx = 0; active = 1'b1; presented = 1'b0;
        end
        if (active) begin
          if (!presented) begin
            exp_q.push_back(pat(gbeat));
            presented = 1'b1;
          end
          m_axi_rvalid = 1'b1;
          m_axi_rdata  = pat(gbeat);
          m_axi_rlast  = (b_idx == b_len - 1) || (b_idx == early_last);
          m_axi_rresp  = (gbeat == resp_err_beat) ? 2'b10 : 2'b00;
        end else begin
          m_axi_rvalid = 1'b0;
          m_axi_rlast  = 1'b0;
          m_axi_rresp  = 2'b00;
        end
        m_axi_arready = 1'b0;
        acc_ar = 1'b0;
        if (m_axi_arvalid) begin
          ar_seen++;
          ar_hold++;
          if (ar_exp_q.size() > 0) chk("araddr", m_axi_araddr, ar_exp_q[0]);
          else chk("ar_extra", ar_exp_q.size(), 1);
          chk("arlen", m_axi_arlen, cur_len - 1);
          chk("arsize", m_axi_arsize, 3);
          chk("arburst", m_axi_arburst, 1);
          chk("arid", m_axi_arid, 0);
          if (ar_hold > ar_delay) begin
            m_axi_arready = 1'b1;
            ar_hold = 0;
            acc_ar = 1'b1;
            if (ar_exp_q.size() > 0) void'(ar_exp_q.pop_front());
          end
        end else if (ar_hold > 0) begin
          chk("ar_drop", m_axi_arvalid, 1'b1);
          ar_hold = 0;
        end
        #1;
        if (active) chk("rready", m_axi_rready, !rd_fifo_full);
        chk("wr_en", rd_fifo_wr_en, active && !rd_fifo_full);
        if (active && rd_fifo_full && !m_axi_rready) stall_seen++;
        if (rd_fifo_wr_en) begin
          pushes++;
          if (exp_q.size() > 0) chk("rdata", rd_fifo_wr_data, exp_q.pop_front());
          else chk("push_extra", exp_q.size(), 1);
        end
        if (stall_left > 0) stall_left--;
        if (active && !rd_fifo_full) begin
          gbeat++; b_idx++; presented = 1'b0;
          if (gbeat == stall_at) stall_left = 5;
          if (m_axi_rlast) begin
            active = 1'b0;
            last_cyc = cyc;
          end
        end
        if (acc_ar) burst_q.push_back(cur_len);
        if (rd_done) begin
          done_cnt++;
          if (data_cmd) chk("done_lat", cyc, last_cyc + 1);
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, rd_ready, 1'b1);
    chk({tag, "_done"}, rd_done, 1'b0);
    chk({tag, "_err"}, rd_err, 1'b0);
    chk({tag, "_arvalid"}, m_axi_arvalid, 1'b0);
    chk({tag, "_rready"}, m_axi_rready, 1'b0);
    chk({tag, "_wr_en"}, rd_fifo_wr_en, 1'b0);
    chk({tag, "_araddr"}, m_axi_araddr, 0);
    chk({tag, "_arlen"}, m_axi_arlen, 0);
  endtask

  task automatic issue(input logic [AW-1:0] a, input int len, input int num);
    for (int b = 0; b < num; b++)
      if (len > 0) ar_exp_q.push_back(a + AW'(b * len * (DW / 8)));
    cur_len  = len;
    gbeat    = 0;
    data_cmd = (len > 0) && (num > 0);
    @(negedge clk);
    rd_burst_len  = BLW'(len);
    rd_num_burst  = NBW'(num);
    rd_start_addr = a;
    rd_start      = 1'b1;
    #2;
    chk("ready_idle", rd_ready, 1'b1);
    @(negedge clk);
    rd_start = 1'b0;
    #2;
    chk("err_clr", rd_err, 1'b0);
    chk("ready_busy", rd_ready, 1'b0);
    if (data_cmd) chk("ar_lat", m_axi_arvalid, 1'b1);
    else chk("done_imm", rd_done, 1'b1);
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input int len, input int num,
                         input bit exp_err, input int exp_pushes);
    int p0, d0, s0, n;
    p0 = pushes; d0 = done_cnt; s0 = ar_seen;
    issue(a, len, num);
    n = 0;
    while (!rd_done && n < 3000) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("done_seen", rd_done, 1'b1);
    chk("err_at_done", rd_err, exp_err);
    @(negedge clk);
    #2;
    chk("ready_back", rd_ready, 1'b1);
    chk("done_single", rd_done, 1'b0);
    chk("err_hold", rd_err, exp_err);
    chk("push_count", pushes - p0, exp_pushes);
    chk("done_count", done_cnt - d0, 1);
    chk("exp_left", exp_q.size(), 0);
    chk("ar_left", ar_exp_q.size(), 0);
    if (!data_cmd) chk("no_ar", ar_seen - s0, 0);
  endtask

  initial begin
    int p0, d0, s0, n;
    rstn = 1'b0; rd_start = 1'b0; rd_burst_len = '0; rd_num_burst = '0; rd_start_addr = '0;
    repeat (3) @(negedge clk);
    #2;
    check_reset_outputs("por");
    #1 rstn = 1'b1;

    run_cmd(29'h100, 4, 2, 1'b0, 8);

    s0 = stall_seen;
    stall_at = 3;
    run_cmd(29'h2000, 8, 1, 1'b0, 8);
    stall_at = -1;
    chk("stall_cycles", stall_seen - s0, 5);

    ar_delay = 3;
    run_cmd(29'h400, 2, 2, 1'b0, 4);
    ar_delay = 0;

    run_cmd(29'h800, 4, 0, 1'b0, 0);
    run_cmd(29'h808, 0, 3, 1'b0, 0);

    resp_err_beat = 1;
    run_cmd(29'h1000, 4, 2, 1'b1, 8);
    resp_err_beat = -1;

    early_last = 1;
    run_cmd(29'h1800, 4, 2, 1'b1, 4);
    early_last = -1;

    run_cmd(29'h3000, 3, 3, 1'b0, 9);
    run_cmd(29'h1FFF_FFF0, 2, 2, 1'b0, 4);

    // Reset while in DATA: abandon, no done pulse, then a clean command.
    p0 = pushes;
    issue(29'h5000, 8, 2);
    n = 0;
    while ((pushes - p0) < 3 && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("rst_reach_data", pushes - p0, 3);
    @(negedge clk);
    #3 rstn = 1'b0;
    #1;
    check_reset_outputs("mid");
    d0 = done_cnt;
    repeat (2) @(negedge clk);
    #3;
    exp_q.delete();
    ar_exp_q.delete();
    rstn = 1'b1;
    #1;
    chk("rel_rready", m_axi_rready, 1'b0);
    chk("rel_ready", rd_ready, 1'b1);
    repeat (5) @(negedge clk);
    #2;
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_push", rd_fifo_wr_en, 1'b0);
    run_cmd(29'h4000, 4, 2, 1'b0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
